weight_stream_loader: RTL and testbench
=======================================

# weight_stream_loader

Receive end of the per-layer coefficient stream. Drains one kernel's worth of `COEFF_WIDTH`-bit weights from an ap_fifo-style stream into a local buffer of `KERN_SIZE` entries, then flags the set as loaded. It serves the loaded coefficients to the convolution datapath through a registered random-access read port. It sits between the weight FIFO (fed by the ROM-backed weight sources) and the MAC array of a conv layer.

## Interface
Parameters:
- `COEFF_WIDTH`, 16: coefficient width in bits.
- `KERN_SIZE`, 9: number of coefficients per load. Must be ≥ 2.
- `AW`, `$clog2(KERN_SIZE)`: address width (derived, not overridden).

Ports:
- `ap_clk`  in  1: the only clock. All logic samples on the rising edge.
- `ap_rst`  in  1: reset, asynchronous, active-high.
- `input_V_dout`  in  COEFF_WIDTH: stream data, first-word-fall-through.
- `input_V_empty_n`  in  1: stream has a valid word on `input_V_dout`.
- `input_V_read`  out  1: consume the current word.
- `load_start`  in  1: one-cycle pulse requesting a (re)load.
- `busy`  out  1: high while in LOAD.
- `load_done`  out  1: level. Buffer holds a complete coefficient set.
- `rd_en`  in  1: read request.
- `rd_addr`  in  AW: read address.
- `rd_data`  out  COEFF_WIDTH: read data, registered.
- `rd_valid`  out  1: `rd_data` is valid this cycle.

## Operation
- Storage: `KERN_SIZE` x `COEFF_WIDTH` array. It is not cleared by reset. Write pointer `wr_ptr` is AW bits wide.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: `load_start` -> LOAD; `wr_ptr` <= 0.
  - LOAD: `input_V_read` = `input_V_empty_n` (combinational, no other gating).
    - On every edge with `input_V_read`=1: mem[`wr_ptr`] <= `input_V_dout` and `wr_ptr` increments.
    - When a word is accepted with `wr_ptr` == KERN_SIZE-1: go to DONE, `load_done` <= 1, `wr_ptr` <= 0.
  - DONE: hold. `load_start` -> LOAD, `load_done` <= 0 on that same edge, `wr_ptr` <= 0.
- `load_start` while in LOAD is ignored. The load is not restarted.
- `input_V_read` is 0 in IDLE and DONE. Words beyond KERN_SIZE are never consumed, so surplus data stays in the FIFO for the next load.
- `busy` = (state == LOAD).
- Read port is active in every state.
  - On `rd_en`: `rd_data` <= mem[`rd_addr`] if `rd_addr` < KERN_SIZE, else 0.
  - `rd_valid` <= `rd_en`.
  - When `rd_en`=0, `rd_data` holds its last value.
- Read and write to the same address on the same edge: `rd_data` returns the old content (read-before-write).
- Reads during LOAD are legal but return a mix of old and new set. The consumer must gate on `load_done`.
- A stalled stream (`empty_n`=0) in LOAD waits indefinitely. There is no timeout.

## Timing
- Reset values: state IDLE, `wr_ptr` 0, `input_V_read` 0, `busy` 0, `load_done` 0, `rd_data` 0, `rd_valid` 0.
- Reset asserted mid-load: immediate return to IDLE with all outputs at reset values. Partially written memory is left as is, and no further FIFO words are consumed.
- Load latency:
  - `load_start` at edge N -> state LOAD from N.
  - First read of the stream possible in cycle N+1.
  - With the stream never empty, the last word is accepted at edge N+KERN_SIZE and `load_done` = 1 from that edge.
- Sustained throughput: 1 word/cycle.
- Read latency: 1 cycle. `rd_en`/`rd_addr` sampled at edge M -> `rd_data`/`rd_valid` valid after edge M.
- `load_done` falls on the same edge that enters LOAD on a reload.

## Test plan
- Basic load (KERN_SIZE=9): FIFO pre-filled with 1..9, pulse `load_start`.
  - Expect exactly 9 `input_V_read` cycles back-to-back, `busy` for 9 cycles, and `load_done` rising on the 9th acceptance.
  - Read addresses 0..8 -> 1..9, each one cycle after `rd_en`.
- Bubbly stream: `empty_n` toggles 1,0,0,1,... with data 0xA0..0xA8.
  - Expect `input_V_read` only when `empty_n`=1 and buffer contents 0xA0..0xA8.
  - `load_done` only after the 9th accepted word.
- Surplus and reload: FIFO holds 18 words 0..17.
  - First load consumes exactly 0..8, then `input_V_read` stays 0 in DONE.
  - Second `load_start` drops `load_done` the same edge and loads 9..17.
  - Read addr 4 -> 13.
- Reset mid-load: assert `ap_rst` after 4 accepted words.
  - Expect all outputs 0 asynchronously and no further reads.
  - After release plus `load_start`, 9 fresh words are loaded correctly.
- Read corner cases:
  - `rd_addr`=9 -> `rd_data` 0.
  - `rd_en` on the same cycle as a write to the same address -> old value returned; a read one cycle later returns the new value.
  - `load_start` during LOAD -> no effect on `wr_ptr` or count.

Source files
------------

// File: rtl/weight_stream_loader_if.sv
// Bundle for the coefficient stream (ap_fifo style, FWFT) and the
// registered random-access read port of weight_stream_loader.
interface weight_stream_loader_if #(
    parameter int COEFF_WIDTH = 16,
    parameter int KERN_SIZE   = 9,
    parameter int AW          = $clog2(KERN_SIZE)
);

    logic [COEFF_WIDTH-1:0] input_V_dout;
    logic                   input_V_empty_n;
    logic                   input_V_read;

    logic                   rd_en;
    logic [AW-1:0]          rd_addr;
    logic [COEFF_WIDTH-1:0] rd_data;
    logic                   rd_valid;

    modport slave (
        input  input_V_dout,
        input  input_V_empty_n,
        output input_V_read,
        input  rd_en,
        input  rd_addr,
        output rd_data,
        output rd_valid
    );

    modport master (
        output input_V_dout,
        output input_V_empty_n,
        input  input_V_read,
        output rd_en,
        output rd_addr,
        input  rd_data,
        input  rd_valid
    );

endinterface

// File: rtl/weight_stream_loader.sv
// Drains one kernel of coefficients from the weight FIFO into a local
// buffer and serves them to the MAC array through a registered read port.
module weight_stream_loader #(
    parameter int COEFF_WIDTH = 16,
    parameter int KERN_SIZE   = 9
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    weight_stream_loader_if.slave   bus,
    input  logic                    load_start,
    output logic                    busy,
    output logic                    load_done
);

    localparam int AW = $clog2(KERN_SIZE);

    // Index of the final coefficient, and the buffer depth widened by one
    // bit so out-of-range read addresses compare correctly.
    localparam logic [AW-1:0] LAST_IDX = AW'(KERN_SIZE - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(KERN_SIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [AW-1:0]          r_wr_ptr;
    logic                   r_load_done;
    logic [COEFF_WIDTH-1:0] r_mem [KERN_SIZE];
    logic [COEFF_WIDTH-1:0] r_rd_data;
    logic                   r_rd_valid;

    logic                   w_accept;
    logic                   w_last;
    logic                   w_rd_in_range;

    // Pull a word whenever loading and the FIFO has one; no other gating,
    // so the stream runs at one word per cycle.
    assign w_accept         = (r_state == S_LOAD) && bus.input_V_empty_n;
    assign w_last           = (r_wr_ptr == LAST_IDX);
    assign w_rd_in_range    = ({1'b0, bus.rd_addr} < DEPTH);

    assign bus.input_V_read = w_accept;
    assign bus.rd_data      = r_rd_data;
    assign bus.rd_valid     = r_rd_valid;
    assign busy             = (r_state == S_LOAD);
    assign load_done        = r_load_done;

    // Load sequencer: IDLE/DONE wait for a start pulse, LOAD counts accepted
    // words and ignores further start pulses until the set is complete.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_load_done <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_state  <= S_LOAD;
                        r_wr_ptr <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_load_done <= 1'b1;
                            r_wr_ptr    <= '0;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + AW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (load_start) begin
                        r_state     <= S_LOAD;
                        r_load_done <= 1'b0;
                        r_wr_ptr    <= '0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_wr_ptr    <= '0;
                    r_load_done <= 1'b0;
                end
            endcase
        end
    end

    // Coefficient buffer write; contents deliberately survive reset so a
    // partial load leaves earlier entries in place.
    always_ff @(posedge ap_clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= bus.input_V_dout;
        end
    end

    // Registered read port, live in every state. Nonblocking update gives
    // read-before-write when the same entry is written on this edge.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_data <= w_rd_in_range ? r_mem[bus.rd_addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed testbench for weight_stream_loader: FIFO model feeding the
// stream, per-scenario tasks with hand-computed expectations.
module tb_weight_stream_loader;

    logic ap_clk = 1'b0;
    logic ap_rst;
    logic load_start;
    logic busy;
    logic load_done;

    int checks = 0;
    int errors = 0;

    weight_stream_loader_if #(.COEFF_WIDTH(16), .KERN_SIZE(9)) bus ();

    weight_stream_loader #(.COEFF_WIDTH(16), .KERN_SIZE(9)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .bus        (bus),
        .load_start (load_start),
        .busy       (busy),
        .load_done  (load_done)
    );

    always #5 ap_clk = ~ap_clk;

    // FIFO model: FWFT data, head advances on edges where the DUT reads.
    logic [15:0] fifo_mem [0:127];
    int          head = 0;
    int          tail = 0;
    logic        gate = 1'b1;
    logic        flush = 1'b0;

    assign bus.input_V_empty_n = gate && (head < tail);
    assign bus.input_V_dout    = (head < tail) ? fifo_mem[head[6:0]] : 16'h0;

    always @(posedge ap_clk) begin
        if (flush) head <= tail;
        else if (bus.input_V_read) head <= head + 1;
    end

    task automatic push(input logic [15:0] v);
        fifo_mem[tail[6:0]] = v;
        tail = tail + 1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge ap_clk);
        flush = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge ap_clk);
        load_start = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        load_start = 1'b0;
        bus.rd_en = 1'b0;
        bus.rd_addr = '0;
        gate = 1'b1;
        push(16'h1234);
        @(negedge ap_clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", load_done); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
        checks++; if (bus.input_V_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b want 0", bus.input_V_read); end
        ap_rst = 1'b0;
        repeat (2) @(negedge ap_clk);
        checks++; if (bus.input_V_read !== 1'b0) begin errors++; $display("FAIL idle_read got %b want 0", bus.input_V_read); end
        checks++; if (head !== 0) begin errors++; $display("FAIL idle_consumed got %0d want 0", head); end
        do_flush();
    endtask

    task automatic test_basic_load();
        int start;
        for (int i = 0; i < 9; i++) push(16'(i + 1));
        start = head;
        pulse_start();
        for (int k = 0; k < 9; k++) begin
            checks++; if (bus.input_V_read !== 1'b1) begin errors++; $display("FAIL basic_read[%0d] got %b want 1", k, bus.input_V_read); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d] got %b want 1", k, busy); end
            checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL basic_early_done[%0d] got %b want 0", k, load_done); end
            @(negedge ap_clk);
        end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", load_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
        checks++; if (head - start !== 9) begin errors++; $display("FAIL basic_count got %0d want 9", head - start); end
        for (int a = 0; a < 9; a++) begin
            bus.rd_en = 1'b1;
            bus.rd_addr = 4'(a);
            @(negedge ap_clk);
            bus.rd_en = 1'b0;
            checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rd_valid[%0d] got %b want 1", a, bus.rd_valid); end
            checks++; if (bus.rd_data !== 16'(a + 1)) begin errors++; $display("FAIL basic_rd[%0d] got %h want %h", a, bus.rd_data, 16'(a + 1)); end
        end
        @(negedge ap_clk);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL basic_rd_valid_drop got %b want 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 16'd9) begin errors++; $display("FAIL basic_rd_hold got %h want 0009", bus.rd_data); end
    endtask

    task automatic test_bubbly();
        int start;
        int acc;
        bit done;
        do_flush();
        for (int i = 0; i < 9; i++) push(16'hA0 + 16'(i));
        start = head;
        gate = 1'b0;
        pulse_start();
        acc = 0;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            gate = (c % 3 == 0);
            #1;
            checks++; if (bus.input_V_read !== gate) begin errors++; $display("FAIL bubbly_read[%0d] got %b want %b", c, bus.input_V_read, gate); end
            if (gate) acc++;
            @(negedge ap_clk);
            if (acc < 9) begin
                checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL bubbly_early_done[%0d] got %b want 0", c, load_done); end
            end else begin
                checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL bubbly_done got %b want 1", load_done); end
                done = 1'b1;
            end
        end
        gate = 1'b1;
        checks++; if (!done) begin errors++; $display("FAIL bubbly_timeout got %0d words want 9", acc); end
        checks++; if (head - start !== 9) begin errors++; $display("FAIL bubbly_count got %0d want 9", head - start); end
        for (int a = 0; a < 9; a++) begin
            bus.rd_en = 1'b1;
            bus.rd_addr = 4'(a);
            @(negedge ap_clk);
            bus.rd_en = 1'b0;
            checks++; if (bus.rd_data !== 16'hA0 + 16'(a)) begin errors++; $display("FAIL bubbly_rd[%0d] got %h want %h", a, bus.rd_data, 16'hA0 + 16'(a)); end
        end
    endtask

    task automatic test_surplus_reload();
        int start;
        do_flush();
        for (int i = 0; i < 18; i++) push(16'(i));
        start = head;
        pulse_start();
        for (int c = 0; c < 40 && !load_done; c++) @(negedge ap_clk);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL surplus_done1 got %b want 1", load_done); end
        checks++; if (head - start !== 9) begin errors++; $display("FAIL surplus_count1 got %0d want 9", head - start); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.input_V_read !== 1'b0) begin errors++; $display("FAIL surplus_done_read[%0d] got %b want 0", c, bus.input_V_read); end
            @(negedge ap_clk);
        end
        checks++; if (head - start !== 9) begin errors++; $display("FAIL surplus_hold got %0d want 9", head - start); end
        pulse_start();
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reload_done_drop got %b want 0", load_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reload_busy got %b want 1", busy); end
        for (int c = 0; c < 40 && !load_done; c++) @(negedge ap_clk);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL surplus_done2 got %b want 1", load_done); end
        checks++; if (head - start !== 18) begin errors++; $display("FAIL surplus_count2 got %0d want 18", head - start); end
        bus.rd_en = 1'b1;
        bus.rd_addr = 4'd4;
        @(negedge ap_clk);
        checks++; if (bus.rd_data !== 16'd13) begin errors++; $display("FAIL reload_rd4 got %h want 000d", bus.rd_data); end
        bus.rd_addr = 4'd0;
        @(negedge ap_clk);
        checks++; if (bus.rd_data !== 16'd9) begin errors++; $display("FAIL reload_rd0 got %h want 0009", bus.rd_data); end
        bus.rd_addr = 4'd8;
        @(negedge ap_clk);
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_data !== 16'd17) begin errors++; $display("FAIL reload_rd8 got %h want 0011", bus.rd_data); end
    endtask

    task automatic test_reset_mid_load();
        int start;
        do_flush();
        for (int i = 0; i < 9; i++) push(16'h50 + 16'(i));
        start = head;
        bus.rd_en = 1'b1;
        bus.rd_addr = 4'd0;
        pulse_start();
        repeat (4) @(negedge ap_clk);
        checks++; if (head - start !== 4) begin errors++; $display("FAIL midrst_pre_count got %0d want 4", head - start); end
        #2;
        ap_rst = 1'b1;
        bus.rd_en = 1'b0;
        #1;
        checks++; if (bus.input_V_read !== 1'b0) begin errors++; $display("FAIL midrst_read got %b want 0", bus.input_V_read); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", load_done); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_rd_valid got %b want 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 16'h0) begin errors++; $display("FAIL midrst_rd_data got %h want 0", bus.rd_data); end
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_busy got %b want 0", busy); end
        checks++; if (head - start !== 4) begin errors++; $display("FAIL midrst_no_reads got %0d want 4", head - start); end
        do_flush();
        for (int i = 0; i < 9; i++) push(16'h60 + 16'(i));
        start = head;
        pulse_start();
        for (int c = 0; c < 40 && !load_done; c++) @(negedge ap_clk);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL midrst_reload_done got %b want 1", load_done); end
        checks++; if (head - start !== 9) begin errors++; $display("FAIL midrst_reload_count got %0d want 9", head - start); end
        for (int a = 0; a < 9; a += 4) begin
            bus.rd_en = 1'b1;
            bus.rd_addr = 4'(a);
            @(negedge ap_clk);
            bus.rd_en = 1'b0;
            checks++; if (bus.rd_data !== 16'h60 + 16'(a)) begin errors++; $display("FAIL midrst_rd[%0d] got %h want %h", a, bus.rd_data, 16'h60 + 16'(a)); end
        end
    endtask

    task automatic test_read_corners();
        int start;
        bus.rd_en = 1'b1;
        bus.rd_addr = 4'd8;
        @(negedge ap_clk);
        checks++; if (bus.rd_data !== 16'h68) begin errors++; $display("FAIL corner_rd8 got %h want 0068", bus.rd_data); end
        bus.rd_addr = 4'd9;
        @(negedge ap_clk);
        checks++; if (bus.rd_data !== 16'h0) begin errors++; $display("FAIL corner_rd9 got %h want 0", bus.rd_data); end
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL corner_rd9_valid got %b want 1", bus.rd_valid); end
        bus.rd_addr = 4'd3;
        @(negedge ap_clk);
        bus.rd_en = 1'b0;
        bus.rd_addr = 4'd15;
        @(negedge ap_clk);
        checks++; if (bus.rd_data !== 16'h63) begin errors++; $display("FAIL corner_hold got %h want 0063", bus.rd_data); end
        bus.rd_en = 1'b1;
        @(negedge ap_clk);
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_data !== 16'h0) begin errors++; $display("FAIL corner_rd15 got %h want 0", bus.rd_data); end
        do_flush();
        for (int i = 0; i < 9; i++) push(16'h70 + 16'(i));
        start = head;
        pulse_start();
        for (int k = 0; k < 9; k++) begin
            if (k == 2) begin
                bus.rd_en = 1'b1;
                bus.rd_addr = 4'd2;
                load_start = 1'b1;
            end else if (k == 3) begin
                load_start = 1'b0;
                checks++; if (bus.rd_data !== 16'h62) begin errors++; $display("FAIL rbw_old got %h want 0062", bus.rd_data); end
            end else if (k == 4) begin
                bus.rd_en = 1'b0;
                checks++; if (bus.rd_data !== 16'h72) begin errors++; $display("FAIL rbw_new got %h want 0072", bus.rd_data); end
            end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy[%0d] got %b want 1", k, busy); end
            checks++; if (head - start !== k) begin errors++; $display("FAIL restart_count[%0d] got %0d want %0d", k, head - start, k); end
            @(negedge ap_clk);
        end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL restart_done got %b want 1", load_done); end
        checks++; if (head - start !== 9) begin errors++; $display("FAIL restart_total got %0d want 9", head - start); end
        for (int a = 0; a < 9; a += 4) begin
            bus.rd_en = 1'b1;
            bus.rd_addr = 4'(a);
            @(negedge ap_clk);
            bus.rd_en = 1'b0;
            checks++; if (bus.rd_data !== 16'h70 + 16'(a)) begin errors++; $display("FAIL restart_rd[%0d] got %h want %h", a, bus.rd_data, 16'h70 + 16'(a)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bubbly();
        test_surplus_reload();
        test_reset_mid_load();
        test_read_corners();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
